dp_rank_filter: RTL
===================

// Module: dp_rank_filter
// PURPOSE
//  Parametrised 3x3 rank-order filter for the DP pixel pipeline, successor to the fixed 3x3 median stage.
//  Consumes a 3x3 mask per channel from an instage_mxn window generator; outputs one pixel per channel.
//  Adds: selectable rank (min..max), multi-channel, impulse-gating threshold, bypass, per-frame config latch.
//  Full 9-input sorting network, 4 register stages, req/rdy backpressure.
// PARAMETERS
//  dw      10  bits per pixel sample
//  ch      1   channels processed in lockstep (e.g. 3 for RGB)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous active-low reset
//  soft_rst       in   1          synchronous clear: pipeline valids, FSM -> IDLE, stat counter
//  op_st          in   1          1-cycle frame start; latches cfg_* and arms FSM
//  cfg_rank       in   4          rank 0=min .. 8=max; values 9..15 treated as 4 (median)
//  cfg_thr_en     in   1          enable impulse gating
//  cfg_thr        in   dw         gating threshold
//  cfg_bypass     in   1          output centre sample unfiltered
//  mask_in        in   ch*9*dw    ch c element k at [(c*9+k+1)*dw-1 : (c*9+k)*dw]; k row-major, k=4 centre
//  rdy_in         in   1          mask_in valid
//  req_out        out  1          block can accept mask_in
//  last_pix_in    in   1          last pixel of line (with rdy_in)
//  last_line_in   in   1          last line of frame (with rdy_in)
//  pix_out        out  ch*dw      result, ch c at [(c+1)*dw-1 : c*dw]
//  rdy_out        out  1          pix_out valid
//  req_in         in   1          downstream accepts pix_out
//  last_pix_out   out  1          sideband aligned with pix_out
//  last_line_out  out  1          sideband aligned with pix_out
//  stat_repl_cnt  out  32         [DP_RANK_FILTER_STAT_EN only] replaced-pixel count of last frame
// BEHAVIOUR
//  - Transfer on either side = rdy && req high at the same rising edge.
//  - Reset (rst_n low): FSM IDLE, all valids 0, pix_out=0, rdy_out=0, last_*_out=0, req_out=0, latched cfg=0.
//  - FSM IDLE: req_out=0; op_st latches cfg_* into shadow regs, -> RUN.
//    FSM RUN: op_st ignored; cfg_* changes ignored; -> IDLE on the output transfer carrying
//    last_pix_out&&last_line_out. Inputs after that input-side transfer are refused until the next op_st.
//  - Pipeline: S1 per-row sort3; S2 column sort / partial merge; S3 complete 9-sort + rank select;
//    S4 gating/bypass mux -> output register. Every stage holds data, valid, last_pix, last_line.
//  - Stall: adv = ~S4.valid | req_in; every stage loads when adv; bubbles collapse.
//    req_out = RUN & adv (combinational on req_in). Throughput 1 pixel/clk.
//  - Latency: with req_in held 1, rdy_out rises after the 4th rising edge following acceptance.
//  - Sort is unsigned, ties stable (any equal value is correct). Rank r = r-th smallest (0-based).
//  - Gating (cfg_thr_en=1): d = |centre - ranked| in dw bits, no overflow.
//    d <= cfg_thr -> output centre; d > cfg_thr -> output ranked.
//  - cfg_bypass=1 overrides rank and gating: output = centre, same 4-cycle latency.
//  - Channels are independent in data; handshake and sideband are shared.
//  - Held output: pix_out/last_* stable while rdy_out=1 & req_in=0.
//  - soft_rst during a frame: in-flight data dropped, rdy_out=0 next cycle, FSM IDLE.
//  - Simultaneous soft_rst and op_st: soft_rst wins.
// CONFIGURATION
//  `define DP_RANK_FILTER_STAT_EN:
//    - 32-bit counter incremented per output transfer where ranked != centre in any channel
//      and bypass=0; saturates at 0xFFFFFFFF.
//    - Copied to stat_repl_cnt at frame end transfer; counter then clears. Reset value 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. ch=1, rank=4, mask k0..8 = {9,1,8,2,7,3,6,4,5}, req_in=1 -> pix_out=5, rdy_out after 4 edges.
//  2. Same mask: rank=0 -> 1; rank=8 -> 9; rank=12 -> 5; bypass=1 -> 7 (centre).
//  3. Centre=100, others=10, rank=4, thr_en=1: thr=50 -> 10; thr=95 -> 100; thr=90 -> 100.
//  4. 16 random masks streamed, req_in low 3 clks mid-stream -> 16 outputs, in order,
//     none lost or duplicated; pix_out held while stalled; req_out=0 while S4 full & req_in=0.
//  5. 4x2 frame, cfg_rank changed 0->8 mid-frame -> all 8 outputs use rank 0;
//     last_*_out on pixel 8 only; req_out=0 after frame until next op_st.
//  6. ch=3, soft_rst 2 clks into frame -> rdy_out=0 next clk, FSM IDLE; with STAT_EN,
//     frame of 4 impulses -> stat_repl_cnt=4.

Source files
------------

// File: rtl/dp_rank_filter_if.sv
// Pixel stream bundle for dp_rank_filter: 3x3 mask input side and
// filtered pixel output side, each with a rdy/req handshake and sideband.
// The slave modport is the filter's view; the master modport is the
// view of the window generator / downstream pair that drives it.
`timescale 1ns/1ps
interface dp_rank_filter_if #(
    parameter int dw = 10,
    parameter int ch = 1
) ();
    logic [ch*9*dw-1:0] mask_in;
    logic               rdy_in;
    logic               req_out;
    logic               last_pix_in;
    logic               last_line_in;
    logic [ch*dw-1:0]   pix_out;
    logic               rdy_out;
    logic               req_in;
    logic               last_pix_out;
    logic               last_line_out;

    modport master (
        output mask_in, rdy_in, last_pix_in, last_line_in, req_in,
        input  req_out, pix_out, rdy_out, last_pix_out, last_line_out
    );

    modport slave (
        input  mask_in, rdy_in, last_pix_in, last_line_in, req_in,
        output req_out, pix_out, rdy_out, last_pix_out, last_line_out
    );
endinterface

// File: rtl/dp_rank_filter.sv
// dp_rank_filter: 3x3 rank-order filter, ch channels in lockstep.
// Four register stages: row sort3, column sort3, full rank select,
// gating/bypass mux into the output register. A single advance enable
// (output register empty or downstream ready) moves the whole pipe.
// Optional replaced-pixel statistics: define DP_RANK_FILTER_STAT_EN.
`timescale 1ns/1ps
module dp_rank_filter #(
    parameter int dw = 10,
    parameter int ch = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soft_rst,
    input  logic            op_st,
    input  logic [3:0]      cfg_rank,
    input  logic            cfg_thr_en,
    input  logic [dw-1:0]   cfg_thr,
    input  logic            cfg_bypass,
    dp_rank_filter_if.slave bus
`ifdef DP_RANK_FILTER_STAT_EN
    ,
    output logic [31:0]     stat_repl_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Sort three samples ascending; result packed as {hi, mid, lo}.
    function automatic logic [3*dw-1:0] sort3(input logic [dw-1:0] a,
                                              input logic [dw-1:0] b,
                                              input logic [dw-1:0] c);
        logic [dw-1:0] lo;
        logic [dw-1:0] hi;
        lo = (a <= b) ? a : b;
        hi = (a <= b) ? b : a;
        if (c < lo)
            sort3 = {hi, lo, c};
        else if (c < hi)
            sort3 = {hi, c, lo};
        else
            sort3 = {c, hi, lo};
    endfunction

    // Frame control and configuration shadow registers.
    logic [0:0]    r_state;
    logic          r_in_done;
    logic [3:0]    r_cfg_rank;
    logic          r_cfg_thr_en;
    logic [dw-1:0] r_cfg_thr;
    logic          r_cfg_bypass;

    // Per-stage valid and sideband; bit 3 is the output register.
    logic [3:0]    r_vld;
    logic [3:0]    r_lpix;
    logic [3:0]    r_lline;

    logic          w_adv;
    logic          w_in_acc;
    logic          w_out_acc;
    logic          w_frame_end;
    logic          w_in_last;

    assign w_adv       = ~r_vld[3] | bus.req_in;
    assign bus.req_out = (r_state == ST_RUN) & ~r_in_done & w_adv;
    assign w_in_acc    = bus.rdy_in & bus.req_out;
    assign w_in_last   = w_in_acc & bus.last_pix_in & bus.last_line_in;
    assign w_out_acc   = r_vld[3] & bus.req_in;
    assign w_frame_end = w_out_acc & r_lpix[3] & r_lline[3];

    assign bus.rdy_out       = r_vld[3];
    assign bus.last_pix_out  = r_lpix[3];
    assign bus.last_line_out = r_lline[3];

`ifdef DP_RANK_FILTER_STAT_EN
    logic [ch-1:0] w_ch_diff;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < ch; gi++) begin : g_ch
            logic [dw-1:0] w_in      [9];
            logic [dw-1:0] w_s1_next [9];
            logic [dw-1:0] w_s2_next [9];
            logic [dw-1:0] w_s3_next;
            logic [dw-1:0] w_s4_next;
            logic [dw-1:0] w_dist;

            logic [dw-1:0] r_s1_data [9];
            logic [dw-1:0] r_s2_data [9];
            logic [dw-1:0] r_s1_centre;
            logic [dw-1:0] r_s2_centre;
            logic [dw-1:0] r_s3_centre;
            logic [dw-1:0] r_s3_rank;
            logic [dw-1:0] r_s4_pix;

            // Unpack this channel's mask and sort each row of three.
            always_comb begin
                for (int k = 0; k < 9; k++)
                    w_in[k] = bus.mask_in[(gi*9+k)*dw +: dw];
                for (int r = 0; r < 3; r++)
                    {w_s1_next[r*3+2], w_s1_next[r*3+1], w_s1_next[r*3]} =
                        sort3(w_in[r*3], w_in[r*3+1], w_in[r*3+2]);
            end

            // Sort each column of the row-sorted matrix.
            always_comb begin
                for (int j = 0; j < 3; j++)
                    {w_s2_next[6+j], w_s2_next[3+j], w_s2_next[j]} =
                        sort3(r_s1_data[j], r_s1_data[3+j], r_s1_data[6+j]);
            end

            // Complete the 9-sort by position counting and pick the
            // configured rank; equal samples are ordered by index so
            // every sample gets a unique position.
            always_comb begin
                w_s3_next = r_s2_data[0];
                for (int k = 0; k < 9; k++) begin
                    logic [3:0] w_pos;
                    w_pos = 4'd0;
                    for (int m = 0; m < 9; m++) begin
                        if (m != k && ((r_s2_data[m] < r_s2_data[k]) ||
                                       (r_s2_data[m] == r_s2_data[k] && m < k)))
                            w_pos = w_pos + 4'd1;
                    end
                    if (w_pos == r_cfg_rank)
                        w_s3_next = r_s2_data[k];
                end
            end

            // Impulse gating and bypass: keep the centre when it is close
            // to the ranked value, otherwise replace it.
            always_comb begin
                w_dist = (r_s3_centre >= r_s3_rank) ? (r_s3_centre - r_s3_rank)
                                                    : (r_s3_rank - r_s3_centre);
                if (r_cfg_bypass)
                    w_s4_next = r_s3_centre;
                else if (r_cfg_thr_en && (w_dist <= r_cfg_thr))
                    w_s4_next = r_s3_centre;
                else
                    w_s4_next = r_s3_rank;
            end

            // Datapath registers for all four stages of this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_data   <= '{default: '0};
                    r_s2_data   <= '{default: '0};
                    r_s1_centre <= '0;
                    r_s2_centre <= '0;
                    r_s3_centre <= '0;
                    r_s3_rank   <= '0;
                    r_s4_pix    <= '0;
                end else if (w_adv) begin
                    r_s1_data   <= w_s1_next;
                    r_s1_centre <= w_in[4];
                    r_s2_data   <= w_s2_next;
                    r_s2_centre <= r_s1_centre;
                    r_s3_rank   <= w_s3_next;
                    r_s3_centre <= r_s2_centre;
                    r_s4_pix    <= w_s4_next;
                end
            end

            assign bus.pix_out[gi*dw +: dw] = r_s4_pix;
`ifdef DP_RANK_FILTER_STAT_EN
            assign w_ch_diff[gi] = (r_s3_rank != r_s3_centre);
`endif
        end
    endgenerate

    // Valid and sideband shift along the pipe; soft reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_lpix  <= '0;
            r_lline <= '0;
        end else if (soft_rst) begin
            r_vld   <= '0;
            r_lpix  <= '0;
            r_lline <= '0;
        end else if (w_adv) begin
            r_vld   <= {r_vld[2:0],   w_in_acc};
            r_lpix  <= {r_lpix[2:0],  w_in_acc & bus.last_pix_in};
            r_lline <= {r_lline[2:0], w_in_acc & bus.last_line_in};
        end
    end

    // Frame FSM: arm on op_st with a config snapshot, stop taking input
    // after the last pixel, return to IDLE once that pixel leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_in_done    <= 1'b0;
            r_cfg_rank   <= 4'd0;
            r_cfg_thr_en <= 1'b0;
            r_cfg_thr    <= '0;
            r_cfg_bypass <= 1'b0;
        end else if (soft_rst) begin
            r_state   <= ST_IDLE;
            r_in_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_st) begin
                        r_state      <= ST_RUN;
                        r_in_done    <= 1'b0;
                        r_cfg_rank   <= (cfg_rank > 4'd8) ? 4'd4 : cfg_rank;
                        r_cfg_thr_en <= cfg_thr_en;
                        r_cfg_thr    <= cfg_thr;
                        r_cfg_bypass <= cfg_bypass;
                    end
                end
                ST_RUN: begin
                    if (w_in_last)
                        r_in_done <= 1'b1;
                    if (w_frame_end)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DP_RANK_FILTER_STAT_EN
    logic        r_s4_repl;
    logic [31:0] r_repl_cnt;
    logic [31:0] r_stat;
    logic [31:0] w_cnt_upd;

    assign w_cnt_upd = (w_out_acc && r_s4_repl && (r_repl_cnt != 32'hFFFF_FFFF))
                       ? (r_repl_cnt + 32'd1) : r_repl_cnt;
    assign stat_repl_cnt = r_stat;

    // Replacement flag travels with the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_s4_repl <= 1'b0;
        else if (w_adv)
            r_s4_repl <= ~r_cfg_bypass & (|w_ch_diff);
    end

    // Saturating per-frame count, published and cleared at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repl_cnt <= 32'd0;
            r_stat     <= 32'd0;
        end else if (soft_rst) begin
            r_repl_cnt <= 32'd0;
        end else if (w_frame_end) begin
            r_stat     <= w_cnt_upd;
            r_repl_cnt <= 32'd0;
        end else begin
            r_repl_cnt <= w_cnt_upd;
        end
    end
`endif

endmodule
